hdmi_layer_fetch_arbiter: RTL and testbench
===========================================

Name: hdmi_layer_fetch_arbiter

Overview:
- Shares one burst-read port of the frame-buffer memory between the two display layers (layer 0 = background, layer 1 = sprite/overlay).
- Each layer feeds a line FIFO that the LCD driver drains via its first/second read enables.
- Issues length-bounded bursts per layer, arbitrates on FIFO level, walks each layer's frame address and restarts cleanly on frame start.
- Runs entirely in the HDMI pixel clock domain, between the memory read controller and the display driver's pixel FIFOs.

Parameters:
- ADDR_W, 24, frame-buffer word address width
- FIFO_AW, 10, layer FIFO address width (depth = 2**FIFO_AW = 1024)
- BURST_LEN, 64, maximum words per burst (1..255)
- LOW_WM, 256, FIFO level below which a layer is urgent
- FRAME_WORDS, 384000, words per layer per frame (800x480)
- BASE0, 24'h000000, layer 0 frame base address
- BASE1, 24'h080000, layer 1 frame base address

Ports:
- hdmi_clk, in, 1, pixel clock; all logic on rising edge
- sys_rst_n, in, 1, asynchronous active-low reset
- frame_start, in, 1, one-cycle pulse at start of vertical blanking
- layer_en, in, 2, per-layer fetch enable, sampled at frame_start
- lvl0, in, FIFO_AW+1, layer 0 FIFO fill level in words
- lvl1, in, FIFO_AW+1, layer 1 FIFO fill level in words
- rd_req, out, 1, burst request, held until rd_ack
- rd_addr, out, ADDR_W, burst start address, stable while rd_req=1
- rd_len, out, 8, burst length in words, stable while rd_req=1
- rd_layer, out, 1, destination layer of the current burst
- rd_ack, in, 1, memory accepted the request
- rd_done, in, 1, one-cycle pulse: last word of the burst written to the FIFO
- fifo_clr, out, 2, one-cycle per-layer FIFO clear pulse on frame restart
- busy, out, 1, burst in flight (REQ or WAIT)
- frame_done, out, 1, one-cycle pulse: all enabled layers fully fetched

Behaviour:
- Reset (async, sys_rst_n=0): all outputs 0, FSM IDLE, addr pointers = bases, remaining counters = 0, rr pointer = 0, en_q = 0.
- FSM states:
  - IDLE -> ARB on frame_start.
  - ARB -> REQ when a layer is eligible; ARB -> IDLE when remaining0=remaining1=0.
  - REQ -> WAIT on rd_ack.
  - WAIT -> ARB on rd_done.
- On frame_start:
  - en_q <= layer_en.
  - remaining_i <= en_q_i ? FRAME_WORDS : 0.
  - ptr_i <= BASE_i.
  - fifo_clr <= 2'b11 for one cycle.
  - If busy, these updates are deferred: a restart_pend flag is set, and the restart is applied in the cycle after rd_done. The in-flight burst still completes.
  - That burst's pointer/count update is discarded.
  - fifo_clr is issued with the deferred restart, so stale words are flushed.
- Eligibility of layer i: en_q_i=1, remaining_i>0, lvl_i <= 2**FIFO_AW - BURST_LEN.
- Arbitration in ARB (1 cycle, levels sampled that cycle):
  - An urgent eligible layer (lvl_i < LOW_WM) beats a non-urgent one.
  - Otherwise round-robin: the layer not granted last wins a tie.
  - The rr pointer updates on grant.
- Request:
  - REQ entry drives rd_req=1, rd_addr=ptr_i, rd_layer=i, rd_len=min(BURST_LEN, remaining_i).
  - Outputs are held until rd_ack is seen high at a rising edge. rd_req drops the cycle after.
  - rd_ack while rd_req=0 is ignored.
- Completion:
  - On rd_done in WAIT: ptr_i += rd_len, remaining_i -= rd_len.
  - Arithmetic is ADDR_W-bit, no wrap.
  - remaining is a 20-bit counter and never underflows because of the min() length.
  - rd_done outside WAIT is ignored.
- frame_done pulses for one cycle when the last remaining counter reaches 0. No pulse if both layers are disabled.
- Latency:
  - Eligible in IDLE/ARB -> rd_req high: 1 cycle.
  - rd_done -> next rd_req: 2 cycles (ARB + REQ).
- Simultaneous frame_start and rd_done in WAIT: the done update is discarded and the restart is applied immediately (no pend).
- Reset mid-burst: everything clears immediately. The memory side is flushed externally by the same reset.

Test Plan:
- Reset, frame_start with layer_en=01, lvl0=0 -> rd_req at cycle 2, rd_addr=0, rd_len=64, rd_layer=0. Ack/done repeatedly -> addresses advance by 64. After 6000 bursts, frame_done pulses once and the FSM is in IDLE.
- layer_en=11, lvl0=lvl1=500 (both non-urgent) -> grants alternate 0,1,0,1; layer 1 addresses start at 24'h080000.
- layer_en=11, lvl0=600, lvl1=100 -> layer 1 granted repeatedly regardless of rr. lvl1=961 -> layer 1 ineligible (961 > 960), layer 0 is granted.
- FRAME_WORDS=100, BURST_LEN=64 -> bursts of 64 then 36. remaining reaches 0 exactly, then frame_done.
- frame_start while in WAIT -> the burst completes, then fifo_clr=11 pulses, ptr0 returns to BASE0, and the next request has rd_addr=BASE0.
- frame_start and rd_done in the same cycle -> no pointer advance, fifo_clr=11 next cycle. Holding rd_ack low for 10 cycles -> rd_addr/rd_len/rd_layer stay stable throughout.

Source files
------------

// File: rtl/hdmi_layer_fetch_arbiter_if.sv
// Burst-read request channel between the layer fetch arbiter (master)
// and the frame-buffer read controller (slave).
interface hdmi_layer_fetch_arbiter_if #(
   parameter int ADDR_W = 24
);
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic [7:0]        rd_len;
   logic              rd_layer;
   logic              rd_ack;
   logic              rd_done;

   modport master (
      output rd_req, rd_addr, rd_len, rd_layer,
      input  rd_ack, rd_done
   );

   modport slave (
      input  rd_req, rd_addr, rd_len, rd_layer,
      output rd_ack, rd_done
   );
endinterface

// File: rtl/hdmi_layer_fetch_arbiter.sv
// Shares one frame-buffer burst-read port between the background and overlay
// layer FIFOs; arbitrates on FIFO level and restarts both layers on frame start.
//
// state  | meaning
// S_IDLE | frame fully fetched, waiting for frame_start
// S_ARB  | one-cycle arbitration between eligible layers
// S_REQ  | burst request presented, waiting for rd_ack
// S_WAIT | burst accepted, waiting for rd_done
module hdmi_layer_fetch_arbiter #(
   parameter int          ADDR_W      = 24,
   parameter int          FIFO_AW     = 10,
   parameter int          BURST_LEN   = 64,
   parameter int          LOW_WM      = 256,
   parameter int          FRAME_WORDS = 384000,
   parameter logic [23:0] BASE0       = 24'h000000,
   parameter logic [23:0] BASE1       = 24'h080000
) (
   input  logic                 hdmi_clk,
   input  logic                 sys_rst_n,
   input  logic                 frame_start,
   input  logic [1:0]           layer_en,
   input  logic [FIFO_AW:0]     lvl0,
   input  logic [FIFO_AW:0]     lvl1,
   hdmi_layer_fetch_arbiter_if.master rd,
   output logic [1:0]           fifo_clr,
   output logic                 busy,
   output logic                 frame_done
);
   localparam int              LVL_W     = FIFO_AW + 1;
   localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'((1 << FIFO_AW) - BURST_LEN);
   localparam logic [LVL_W-1:0] LVL_LOW  = LVL_W'(LOW_WM);
   localparam logic [19:0]      FRAME_W  = 20'(FRAME_WORDS);
   localparam logic [19:0]      BURST_W  = 20'(BURST_LEN);

   typedef enum logic [1:0] {S_IDLE, S_ARB, S_REQ, S_WAIT} state_t;

   state_t            state_q, state_d;
   logic [1:0]        en_q, en_d;
   logic              pend_q, pend_d;
   logic [1:0]        pend_en_q, pend_en_d;
   logic [ADDR_W-1:0] ptr0_q, ptr0_d, ptr1_q, ptr1_d;
   logic [19:0]       rem0_q, rem0_d, rem1_q, rem1_d;
   logic              rr_q, rr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        len_q, len_d;
   logic              layer_q, layer_d;
   logic [1:0]        fifo_clr_q, fifo_clr_d;
   logic              frame_done_q, frame_done_d;

   logic              elig0, elig1, urg0, urg1, gnt, restart;
   logic [1:0]        restart_en;
   logic [19:0]       gnt_rem;

   always_comb begin
      elig0   = en_q[0] && (rem0_q != '0) && (lvl0 <= LVL_MAX);
      elig1   = en_q[1] && (rem1_q != '0) && (lvl1 <= LVL_MAX);
      urg0    = elig0 && (lvl0 < LVL_LOW);
      urg1    = elig1 && (lvl1 < LVL_LOW);
      // urgency first, then round-robin preference, else whichever is eligible
      if (urg0 != urg1)       gnt = urg1;
      else if (elig0 && elig1) gnt = rr_q;
      else                     gnt = ~elig0;
      gnt_rem = gnt ? rem1_q : rem0_q;
   end

   always_comb begin
      state_d      = state_q;
      en_d         = en_q;
      pend_d       = pend_q;
      pend_en_d    = pend_en_q;
      ptr0_d       = ptr0_q;
      ptr1_d       = ptr1_q;
      rem0_d       = rem0_q;
      rem1_d       = rem1_q;
      rr_d         = rr_q;
      addr_d       = addr_q;
      len_d        = len_q;
      layer_d      = layer_q;
      fifo_clr_d   = 2'b00;
      frame_done_d = 1'b0;
      restart      = 1'b0;
      restart_en   = layer_en;

      case (state_q)
         S_IDLE: begin
            if (frame_start) begin
               restart = 1'b1;
               state_d = S_ARB;
            end
         end
         S_ARB: begin
            if (frame_start) begin
               restart = 1'b1;
            end else if (elig0 || elig1) begin
               state_d = S_REQ;
               layer_d = gnt;
               addr_d  = gnt ? ptr1_q : ptr0_q;
               len_d   = (gnt_rem < BURST_W) ? gnt_rem[7:0] : BURST_W[7:0];
               rr_d    = ~gnt;
            end else if ((rem0_q == '0) && (rem1_q == '0)) begin
               state_d = S_IDLE;
            end
         end
         S_REQ: begin
            if (frame_start) begin
               pend_d    = 1'b1;
               pend_en_d = layer_en;
            end
            if (rd.rd_ack) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (rd.rd_done) begin
               state_d = S_ARB;
               // a pending or coincident restart discards this burst's update
               if (frame_start) begin
                  restart = 1'b1;
               end else if (pend_q) begin
                  restart    = 1'b1;
                  restart_en = pend_en_q;
               end else begin
                  if (layer_q) begin
                     ptr1_d = ptr1_q + ADDR_W'(len_q);
                     rem1_d = rem1_q - 20'(len_q);
                  end else begin
                     ptr0_d = ptr0_q + ADDR_W'(len_q);
                     rem0_d = rem0_q - 20'(len_q);
                  end
                  frame_done_d = (rem0_d == '0) && (rem1_d == '0);
               end
            end else if (frame_start) begin
               pend_d    = 1'b1;
               pend_en_d = layer_en;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (restart) begin
         en_d       = restart_en;
         rem0_d     = restart_en[0] ? FRAME_W : '0;
         rem1_d     = restart_en[1] ? FRAME_W : '0;
         ptr0_d     = ADDR_W'(BASE0);
         ptr1_d     = ADDR_W'(BASE1);
         fifo_clr_d = 2'b11;
         pend_d     = 1'b0;
      end
   end

   always_ff @(posedge hdmi_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q      <= S_IDLE;
         en_q         <= '0;
         pend_q       <= 1'b0;
         pend_en_q    <= '0;
         ptr0_q       <= ADDR_W'(BASE0);
         ptr1_q       <= ADDR_W'(BASE1);
         rem0_q       <= '0;
         rem1_q       <= '0;
         rr_q         <= 1'b0;
         addr_q       <= '0;
         len_q        <= '0;
         layer_q      <= 1'b0;
         fifo_clr_q   <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         en_q         <= en_d;
         pend_q       <= pend_d;
         pend_en_q    <= pend_en_d;
         ptr0_q       <= ptr0_d;
         ptr1_q       <= ptr1_d;
         rem0_q       <= rem0_d;
         rem1_q       <= rem1_d;
         rr_q         <= rr_d;
         addr_q       <= addr_d;
         len_q        <= len_d;
         layer_q      <= layer_d;
         fifo_clr_q   <= fifo_clr_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign rd.rd_req   = (state_q == S_REQ);
   assign rd.rd_addr  = addr_q;
   assign rd.rd_len   = len_q;
   assign rd.rd_layer = layer_q;
   assign busy        = (state_q == S_REQ) || (state_q == S_WAIT);
   assign fifo_clr    = fifo_clr_q;
   assign frame_done  = frame_done_q;
endmodule

// File: tb/tb_hdmi_layer_fetch_arbiter.sv
// Scoreboard bench for hdmi_layer_fetch_arbiter with a 100-word frame so that
// every frame ends in a 64-word burst followed by a 36-word tail burst.
module tb_hdmi_layer_fetch_arbiter;
   localparam int ADDR_W  = 24;
   localparam int FIFO_AW = 10;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               frame_start = 1'b0;
   logic [1:0]         layer_en = 2'b00;
   logic [FIFO_AW:0]   lvl0 = '0;
   logic [FIFO_AW:0]   lvl1 = '0;
   logic [1:0]         fifo_clr;
   logic               busy;
   logic               frame_done;

   hdmi_layer_fetch_arbiter_if #(.ADDR_W(ADDR_W)) rif ();

   hdmi_layer_fetch_arbiter #(
      .ADDR_W(ADDR_W), .FIFO_AW(FIFO_AW), .BURST_LEN(64), .LOW_WM(256),
      .FRAME_WORDS(100), .BASE0(24'h000000), .BASE1(24'h080000)
   ) dut (
      .hdmi_clk   (clk),
      .sys_rst_n  (rst_n),
      .frame_start(frame_start),
      .layer_en   (layer_en),
      .lvl0       (lvl0),
      .lvl1       (lvl1),
      .rd         (rif),
      .fifo_clr   (fifo_clr),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [23:0] addr;
      logic [7:0]  len;
      logic        layer;
   } req_t;

   req_t exp_q[$];
   int   cmp_cnt = 0;
   int   err_cnt = 0;
   int   fd_cnt  = 0;
   logic req_seen = 1'b0;

   initial begin
      rif.rd_ack  = 1'b0;
      rif.rd_done = 1'b0;
   end

   // monitor: every new request is popped against the expected queue
   always @(negedge clk) begin
      req_t e;
      if (rif.rd_req && !req_seen) begin
         cmp_cnt++;
         if (exp_q.size() == 0) begin
            err_cnt++;
            $display("FAIL unexpected_req: got addr=%h len=%0d layer=%0d, none expected",
                     rif.rd_addr, rif.rd_len, rif.rd_layer);
         end else begin
            e = exp_q.pop_front();
            if (rif.rd_addr !== e.addr || rif.rd_len !== e.len || rif.rd_layer !== e.layer) begin
               err_cnt++;
               $display("FAIL req: got addr=%h len=%0d layer=%0d expected addr=%h len=%0d layer=%0d",
                        rif.rd_addr, rif.rd_len, rif.rd_layer, e.addr, e.len, e.layer);
            end
         end
      end
      req_seen = rif.rd_req;
      if (frame_done === 1'b1) fd_cnt++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [23:0] a, input logic [7:0] l, input logic ly);
      req_t r;
      r.addr = a; r.len = l; r.layer = ly;
      exp_q.push_back(r);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; frame_start = 1'b0; rif.rd_ack = 1'b0; rif.rd_done = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(1);
   endtask

   task automatic start_frame(input logic [1:0] en);
      layer_en = en; frame_start = 1'b1;
      tick(1);
      frame_start = 1'b0;
   endtask

   task automatic wait_req();
      int n = 0;
      while (rif.rd_req !== 1'b1 && n < 50) begin
         tick(1);
         n++;
      end
      check("req_timeout", rif.rd_req, 1);
   endtask

   task automatic ack_req();
      wait_req();
      rif.rd_ack = 1'b1;
      tick(1);
      rif.rd_ack = 1'b0;
   endtask

   task automatic give_done(input int n);
      tick(n);
      rif.rd_done = 1'b1;
      tick(1);
      rif.rd_done = 1'b0;
   endtask

   task automatic burst();
      ack_req();
      give_done(2);
   endtask

   initial begin
      #1;
      do_reset();
      check("rst_req", rif.rd_req, 0);
      check("rst_busy", busy, 0);
      check("rst_fifo_clr", fifo_clr, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_addr", rif.rd_addr, 0);
      check("rst_len", rif.rd_len, 0);

      rif.rd_ack = 1'b1; rif.rd_done = 1'b1;
      tick(1);
      rif.rd_ack = 1'b0; rif.rd_done = 1'b0;
      check("stray_busy", busy, 0);
      check("stray_req", rif.rd_req, 0);

      // single layer: 64 + 36 words, first request two cycles after frame_start
      push(24'h000000, 8'd64, 1'b0);
      push(24'h000040, 8'd36, 1'b0);
      lvl0 = 11'd0; lvl1 = 11'd0;
      start_frame(2'b01);
      check("t1_fifo_clr", fifo_clr, 2'b11);
      check("t1_req_early", rif.rd_req, 0);
      tick(1);
      check("t1_fifo_clr_pulse", fifo_clr, 2'b00);
      check("t1_req_latency", rif.rd_req, 1);
      burst();
      burst();
      tick(3);
      check("t1_frame_done", fd_cnt, 1);
      check("t1_idle", busy, 0);

      // two non-urgent layers alternate
      do_reset();
      push(24'h000000, 8'd64, 1'b0);
      push(24'h080000, 8'd64, 1'b1);
      push(24'h000040, 8'd36, 1'b0);
      push(24'h080040, 8'd36, 1'b1);
      lvl0 = 11'd500; lvl1 = 11'd500;
      start_frame(2'b11);
      repeat (4) burst();
      tick(3);
      check("t2_frame_done", fd_cnt, 2);

      // urgency beats round-robin; level above 960 makes a layer ineligible
      do_reset();
      push(24'h080000, 8'd64, 1'b1);
      push(24'h000000, 8'd64, 1'b0);
      push(24'h080040, 8'd36, 1'b1);
      push(24'h000040, 8'd36, 1'b0);
      lvl0 = 11'd600; lvl1 = 11'd100;
      start_frame(2'b11);
      ack_req();
      lvl1 = 11'd961;
      give_done(2);
      ack_req();
      lvl1 = 11'd100;
      give_done(2);
      burst();
      burst();
      tick(3);
      check("t3_frame_done", fd_cnt, 3);

      // frame_start while a burst is in flight is deferred to its rd_done
      do_reset();
      push(24'h000000, 8'd64, 1'b0);
      push(24'h000000, 8'd64, 1'b0);
      push(24'h000040, 8'd36, 1'b0);
      lvl0 = 11'd0; lvl1 = 11'd0;
      start_frame(2'b01);
      ack_req();
      start_frame(2'b01);
      tick(2);
      check("t4_clr_deferred", fifo_clr, 2'b00);
      check("t4_busy", busy, 1);
      give_done(0);
      check("t4_clr_after_done", fifo_clr, 2'b11);
      check("t4_not_busy", busy, 0);
      burst();
      burst();
      tick(3);
      check("t4_frame_done", fd_cnt, 4);

      // frame_start coincident with rd_done, then a long-held request
      do_reset();
      push(24'h000000, 8'd64, 1'b0);
      push(24'h000000, 8'd64, 1'b0);
      push(24'h000040, 8'd36, 1'b0);
      start_frame(2'b01);
      ack_req();
      tick(1);
      frame_start = 1'b1; rif.rd_done = 1'b1;
      tick(1);
      frame_start = 1'b0; rif.rd_done = 1'b0;
      check("t5_clr", fifo_clr, 2'b11);
      wait_req();
      for (int i = 0; i < 10; i++) begin
         check("t5_hold_req", rif.rd_req, 1);
         check("t5_hold_addr", rif.rd_addr, 24'h000000);
         check("t5_hold_len", rif.rd_len, 8'd64);
         check("t5_hold_layer", rif.rd_layer, 0);
         tick(1);
      end
      ack_req();
      give_done(2);
      burst();
      tick(5);
      check("t5_frame_done", fd_cnt, 5);
      check("exp_queue_empty", exp_q.size(), 0);
      check("final_idle", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
